// File: rtl/mii_pkg.sv
// Shared codes and enums for the MII frame checker.
package mii_pkg;
  localparam logic [7:0] IDLE_CODE     = 8'h07;
  localparam logic [7:0] START_CODE    = 8'hFB;
  localparam logic [7:0] TERM_CODE     = 8'hFD;
  localparam logic [7:0] PREAMBLE_CODE = 8'h55;
  localparam logic [7:0] SFD_CODE      = 8'hD5;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_BAD_PREAMBLE = 3'd1,
    ERR_UNEXP_CTRL   = 3'd2,
    ERR_NO_TERM      = 3'd3,
    ERR_SHORT        = 3'd4,
    ERR_LONG         = 3'd5
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/mii_lane_decoder.sv
// Per-block lane scan: lowest control lane, any terminate, and whether all
// lanes above the lowest control lane are idle characters.
module mii_lane_decoder
  import mii_pkg::*;
#(
  parameter int LANES = 8,
  localparam int IW = $clog2(LANES)
) (
  input  logic [LANES*8-1:0] data,
  input  logic [LANES-1:0]   ctrl,
  output logic [IW-1:0]      low_lane,
  output logic               term_present,
  output logic               upper_idle
);
  logic [LANES-1:0] is_idle, is_term;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign is_idle[g] = ctrl[g] && (data[8*g +: 8] == IDLE_CODE);
    assign is_term[g] = ctrl[g] && (data[8*g +: 8] == TERM_CODE);
  end

  assign term_present = |is_term;

  always_comb begin
    low_lane = '0;
    // Scan downward so the last hit is the lowest set lane.
    for (int i = LANES - 1; i >= 0; i--)
      if (ctrl[i]) low_lane = IW'(i);
    upper_idle = 1'b1;
    for (int i = 0; i < LANES; i++)
      if ((IW'(i) > low_lane) && !is_idle[i]) upper_idle = 1'b0;
  end
endmodule

// File: rtl/mii_frame_checker.sv
// Checks 64-bit MII block stream for frame structure and length, reporting
// one registered pulse per frame outcome with saturating counters.
module mii_frame_checker
  import mii_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
  output logic                  o_frame_valid,
  output logic                  o_frame_error,
  output logic [2:0]            o_err_code,
  output logic [15:0]           o_frame_len,
  output logic [15:0]           o_good_count,
  output logic [15:0]           o_err_count
);
  localparam int IW = $clog2(CTRL_WIDTH);

  state_e          state, nxt_state;
  logic [15:0]     len, nxt_len, data_len, term_len, rep_len;
  logic [IW-1:0]   low_lane;
  logic            term_present, upper_idle;
  logic [7:0]      low_byte;
  logic            all_idle, start_ok, start_like, rep;
  err_e            rep_code;

  mii_lane_decoder #(.LANES(CTRL_WIDTH)) u_dec (
    .data         (i_rx_data),
    .ctrl         (i_rx_ctrl),
    .low_lane     (low_lane),
    .term_present (term_present),
    .upper_idle   (upper_idle)
  );

  assign low_byte   = i_rx_data[{low_lane, 3'b000} +: 8];
  assign all_idle   = (i_rx_ctrl == '1) && (i_rx_data == {CTRL_WIDTH{IDLE_CODE}});
  assign start_like = (i_rx_ctrl == CTRL_WIDTH'(1)) && (i_rx_data[7:0] == START_CODE);
  assign start_ok   = start_like &&
                      (i_rx_data == {SFD_CODE, {(CTRL_WIDTH-2){PREAMBLE_CODE}}, START_CODE});
  assign data_len   = len + 16'd8;
  assign term_len   = len + 16'(low_lane);

  always_comb begin
    nxt_state = state;
    nxt_len   = len;
    rep       = 1'b0;
    rep_code  = ERR_NONE;
    rep_len   = len;
    case (state)
      ST_IDLE: begin
        rep_len = '0;
        if (start_ok) begin
          nxt_state = ST_DATA;
          nxt_len   = '0;
        end else if (start_like) begin
          rep       = 1'b1;
          rep_code  = ERR_BAD_PREAMBLE;
          nxt_state = ST_DRAIN;
        end else if (!all_idle) begin
          rep      = 1'b1;
          rep_code = ERR_UNEXP_CTRL;
        end
      end
      ST_DATA: begin
        if (i_rx_ctrl == '0) begin
          nxt_len = data_len;
          // Runaway frame: give up before a terminate ever arrives.
          if (data_len > 16'(MAX_FRAME_BYTES + 8)) begin
            rep       = 1'b1;
            rep_code  = ERR_LONG;
            rep_len   = data_len;
            nxt_state = ST_DRAIN;
          end
        end else if ((low_byte == TERM_CODE) && upper_idle) begin
          rep       = 1'b1;
          rep_len   = term_len;
          nxt_len   = term_len;
          nxt_state = ST_IDLE;
          if (term_len < 16'(MIN_FRAME_BYTES))      rep_code = ERR_SHORT;
          else if (term_len > 16'(MAX_FRAME_BYTES)) rep_code = ERR_LONG;
        end else begin
          rep       = 1'b1;
          rep_code  = (low_byte == START_CODE) ? ERR_NO_TERM : ERR_UNEXP_CTRL;
          nxt_state = ST_DRAIN;
        end
      end
      ST_DRAIN: if (term_present || all_idle) nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      len           <= '0;
      o_frame_valid <= 1'b0;
      o_frame_error <= 1'b0;
      o_err_code    <= '0;
      o_frame_len   <= '0;
      o_good_count  <= '0;
      o_err_count   <= '0;
    end else begin
      state         <= nxt_state;
      len           <= nxt_len;
      o_frame_valid <= rep && (rep_code == ERR_NONE);
      o_frame_error <= rep && (rep_code != ERR_NONE);
      if (rep) begin
        o_err_code  <= rep_code;
        o_frame_len <= rep_len;
        if (rep_code == ERR_NONE) begin
          if (o_good_count != 16'hFFFF) o_good_count <= o_good_count + 16'd1;
        end else begin
          if (o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mii_frame_checker.sv
// Directed and randomized frame-level checks of mii_frame_checker against
// expectations derived from frame byte counts.
module tb_mii_frame_checker;
  localparam logic [2:0] C_NONE = 3'd0, C_BADPRE = 3'd1, C_UNEXP = 3'd2,
                         C_NOTERM = 3'd3, C_SHORT = 3'd4, C_LONG = 3'd5;
  localparam logic [63:0] IDLE_BLK  = 64'h0707070707070707;
  localparam logic [63:0] START_BLK = 64'hD5555555555555FB;
  localparam logic [63:0] BADPR_BLK = 64'hD4555555555555FB;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rx_data;
  logic [7:0]  rx_ctrl;
  logic        frame_valid, frame_error;
  logic [2:0]  err_code;
  logic [15:0] frame_len, good_count, err_count;

  int tests = 0;
  int fails = 0;
  logic [2:0]  m_code;
  logic [15:0] m_len, m_good, m_err;

  always #5 clk = ~clk;

  mii_frame_checker dut (
    .clk           (clk),
    .i_rst         (rst),
    .i_rx_data     (rx_data),
    .i_rx_ctrl     (rx_ctrl),
    .o_frame_valid (frame_valid),
    .o_frame_error (frame_error),
    .o_err_code    (err_code),
    .o_frame_len   (frame_len),
    .o_good_count  (good_count),
    .o_err_count   (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = no report expected, 1 = good frame, 2 = error report
  task automatic step(input logic [63:0] d, input logic [7:0] c, input int kind,
                      input logic [2:0] code, input logic [15:0] len);
    rx_data = d;
    rx_ctrl = c;
    @(posedge clk);
    #1;
    if (kind != 0) begin
      m_code = code;
      m_len  = len;
      if (kind == 1) m_good++;
      else           m_err++;
    end
    chk("frame_valid", {31'd0, frame_valid}, {31'd0, kind == 1});
    chk("frame_error", {31'd0, frame_error}, {31'd0, kind == 2});
    chk("err_code",    {29'd0, err_code},    {29'd0, m_code});
    chk("frame_len",   {16'd0, frame_len},   {16'd0, m_len});
    chk("good_count",  {16'd0, good_count},  {16'd0, m_good});
    chk("err_count",   {16'd0, err_count},   {16'd0, m_err});
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Terminate at lane k: lanes below are data, lane k is FD, lanes above idle.
  function automatic logic [63:0] term_blk(input int k);
    logic [63:0] d = rnd64();
    d[8*k +: 8] = 8'hFD;
    for (int j = k + 1; j < 8; j++) d[8*j +: 8] = 8'h07;
    return d;
  endfunction

  function automatic logic [7:0] term_ctrl(input int k);
    logic [7:0] m = 8'hFF;
    return m << k;
  endfunction

  // Complete frame of n bytes (n <= 1526), outcome judged only from n.
  task automatic frame(input int n);
    int k  = n % 8;
    int nb = n / 8;
    step(START_BLK, 8'h01, 0, 3'd0, 16'd0);
    for (int i = 0; i < nb; i++) step(rnd64(), 8'h00, 0, 3'd0, 16'd0);
    if (n < 64)        step(term_blk(k), term_ctrl(k), 2, C_SHORT, 16'(n));
    else if (n > 1518) step(term_blk(k), term_ctrl(k), 2, C_LONG,  16'(n));
    else               step(term_blk(k), term_ctrl(k), 1, C_NONE,  16'(n));
  endtask

  initial begin
    m_code = '0; m_len = '0; m_good = '0; m_err = '0;
    rst = 1'b1;
    rx_data = IDLE_BLK;
    rx_ctrl = 8'hFF;
    step(START_BLK, 8'h01, 0, 3'd0, 16'd0);
    step(START_BLK, 8'h01, 0, 3'd0, 16'd0);
    rst = 1'b0;

    step(IDLE_BLK, 8'hFF, 0, 3'd0, 16'd0);
    frame(64);
    frame(59);

    // Bad preamble, then ignored data until a terminate is seen
    step(BADPR_BLK, 8'h01, 2, C_BADPRE, 16'd0);
    step(rnd64(), 8'h00, 0, 3'd0, 16'd0);
    step(START_BLK, 8'h01, 0, 3'd0, 16'd0);
    step(term_blk(2), term_ctrl(2), 0, 3'd0, 16'd0);
    frame(100);

    // Second start before terminate
    step(START_BLK, 8'h01, 0, 3'd0, 16'd0);
    for (int i = 0; i < 3; i++) step(rnd64(), 8'h00, 0, 3'd0, 16'd0);
    step(START_BLK, 8'h01, 2, C_NOTERM, 16'd24);
    step(rnd64(), 8'h00, 0, 3'd0, 16'd0);
    step(IDLE_BLK, 8'hFF, 0, 3'd0, 16'd0);
    frame(72);

    // Runaway frame: LONG once length passes 1526, then silence
    step(START_BLK, 8'h01, 0, 3'd0, 16'd0);
    for (int i = 1; i <= 200; i++) begin
      if (i * 8 > 1526 && (i - 1) * 8 <= 1526)
        step(rnd64(), 8'h00, 2, C_LONG, 16'(i * 8));
      else
        step(rnd64(), 8'h00, 0, 3'd0, 16'd0);
    end
    step(IDLE_BLK, 8'hFF, 0, 3'd0, 16'd0);

    // Length boundaries
    frame(63);
    frame(1518);
    frame(1519);
    frame(1526);
    frame(0);

    // Unexpected control in IDLE and in DATA
    step(rnd64(), 8'h00, 2, C_UNEXP, 16'd0);
    step(START_BLK, 8'h01, 0, 3'd0, 16'd0);
    for (int i = 0; i < 8; i++) step(rnd64(), 8'h00, 0, 3'd0, 16'd0);
    begin
      logic [63:0] d = term_blk(2);
      d[55:48] = 8'h1C;
      step(d, 8'hFC, 2, C_UNEXP, 16'd64);
    end
    step(IDLE_BLK, 8'hFF, 0, 3'd0, 16'd0);

    // Reset mid-frame discards everything
    step(START_BLK, 8'h01, 0, 3'd0, 16'd0);
    for (int i = 0; i < 4; i++) step(rnd64(), 8'h00, 0, 3'd0, 16'd0);
    rst = 1'b1;
    m_code = '0; m_len = '0; m_good = '0; m_err = '0;
    step(rnd64(), 8'h00, 0, 3'd0, 16'd0);
    rst = 1'b0;
    frame(64);

    // Randomized frames, half of them near the short boundary
    for (int f = 0; f < 16; f++) begin
      int n   = (f % 2 == 1) ? $urandom_range(0, 1526) : $urandom_range(56, 72);
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step(IDLE_BLK, 8'hFF, 0, 3'd0, 16'd0);
      frame(n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mii_frame_checker.md
MII_FRAME_CHECKER -- requirements
Module: mii_frame_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, giving the data bus width; only 64 is supported.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, giving one control bit per byte lane.
REQ-003 SHALL have parameter MIN_FRAME_BYTES, default 64, giving the minimum legal byte count from SFD (exclusive) to terminate (exclusive).
REQ-004 SHALL have parameter MAX_FRAME_BYTES, default 1518, giving the maximum legal byte count, same measure.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port i_rx_data, input, DATA_WIDTH bits: block from upstream; lane n is bits [8n+7:8n], lane 0 first on the wire.
REQ-008 SHALL have port i_rx_ctrl, input, CTRL_WIDTH bits: bit n=1 marks lane n as a control character.
REQ-009 SHALL have port o_frame_valid, output, 1 bit: one-cycle pulse for a good frame.
REQ-010 SHALL have port o_frame_error, output, 1 bit: one-cycle pulse for a bad frame or block.
REQ-011 SHALL have port o_err_code, output, 3 bits: reason, held until the next pulse (0 NONE, 1 BAD_PREAMBLE, 2 UNEXP_CTRL, 3 NO_TERM, 4 SHORT, 5 LONG).
REQ-012 SHALL have port o_frame_len, output, 16 bits: byte count of the last reported frame, held.
REQ-013 SHALL have port o_good_count, output, 16 bits: good-frame counter, saturating at 16'hFFFF.
REQ-014 SHALL have port o_err_count, output, 16 bits: error counter, saturating at 16'hFFFF.

Function
REQ-015 SHALL implement FSM states IDLE, DATA and DRAIN; all outputs registered; report latency is 1 cycle after the deciding block is sampled.
REQ-016 In IDLE, an all-idle block (ctrl 8'hFF, every lane 8'h07) SHALL keep IDLE with no report.
REQ-017 In IDLE, a start block (ctrl 8'h01, lane0 8'hFB, lanes1-6 8'h55, lane7 8'hD5) SHALL enter DATA with the length reset to 0.
REQ-018 In IDLE, a block with lane0 8'hFB and ctrl 8'h01 but a wrong preamble or SFD SHALL report BAD_PREAMBLE and enter DRAIN.
REQ-019 In IDLE, any other block SHALL report UNEXP_CTRL and stay in IDLE.
REQ-020 In DATA, ctrl 8'h00 SHALL add 8 to the length and stay in DATA.
REQ-021 In DATA, when nonzero ctrl has lowest set lane k holding 8'hFD, and every lane above k is control 8'h07, the block SHALL add k to the length and end the frame.
REQ-022 A frame that ends with a length in [MIN_FRAME_BYTES, MAX_FRAME_BYTES] SHALL report valid; below the range SHALL report SHORT; above SHALL report LONG; either way SHALL return to IDLE.
REQ-023 In DATA, when the lowest control lane holds 8'hFB, SHALL report NO_TERM and enter DRAIN.
REQ-024 In DATA, any other control pattern, including an 8'hFD terminate with non-idle upper lanes, SHALL report UNEXP_CTRL and enter DRAIN.
REQ-025 In DATA, when the length exceeds MAX_FRAME_BYTES+8, SHALL report LONG immediately and enter DRAIN.
REQ-026 In DRAIN, a block containing a control 8'hFD or an all-idle block SHALL return to IDLE with no report; any other block SHALL stay in DRAIN.
REQ-027 Every report SHALL update o_err_code (0 for valid) and o_frame_len (the length so far) in the same cycle as the pulse.
REQ-028 o_frame_valid and o_frame_error SHALL never be high together.
REQ-029 A report SHALL increment exactly one counter; counters at 16'hFFFF SHALL hold.

Reset
REQ-030 While i_rst=1 at a clk edge, the FSM SHALL go to IDLE, and the length, both pulses, o_err_code, o_frame_len and both counters SHALL go to 0.
REQ-031 Reset mid-frame SHALL discard the frame with no report; the first post-reset block is decoded per REQ-016..019.

Structure
REQ-032 Package mii_pkg SHALL hold the IDLE/START/TERMINATE/PREAMBLE/SFD codes, the error-code enum and the FSM state enum.
REQ-033 Sub-module mii_lane_decoder SHALL be combinational and produce the lowest set ctrl lane index, a terminate-present flag and an upper-lanes-idle flag.

Verification
REQ-034 Start block, 8 blocks of ctrl 8'h00, then {7x07,FD} with ctrl 8'hFF -> o_frame_valid pulse, len=64, good_count=1.
REQ-035 Same frame with 7 data blocks plus terminate at lane 3 (ctrl 8'hF8) -> o_frame_error, code SHORT, len=59.
REQ-036 Start block with lane7 8'hD4 -> code BAD_PREAMBLE; data blocks then ignored until FD; err_count=1.
REQ-037 Start, 3 data blocks, then a second start block -> code NO_TERM, len=24, DRAIN; next full frame -> valid.
REQ-038 200 data blocks with no terminate -> single LONG report once len exceeds 1526; no further report.
REQ-039 i_rst asserted mid-frame -> no pulse, counters 0, next good frame -> good_count=1.
